// File: rtl/spi_slave_reply_scheduler_pkg.sv
// Shared definitions for the SPI slave reply scheduler: FSM state encodings,
// rx_src tags and the SS polarity helper.
package spi_slave_reply_scheduler_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StArmed = 3'd1,
      StBusy  = 3'd2,
      StDone  = 3'd3
   } state_e;

   localparam logic [1:0] RxSrcNone = 2'b00;
   localparam logic [1:0] RxSrcInj  = 2'b01;
   localparam logic [1:0] RxSrcFwd  = 2'b10;

   // Normalise the raw SS line to "window open".
   function automatic logic ss_is_active(input logic ss, input logic active_low);
      return active_low ? ~ss : ss;
   endfunction

endpackage

// File: rtl/spi_slave_reply_scheduler_reply_arbiter.sv
// Per-word grant between the injection and forward sources, with a starvation
// counter that forces a forward grant after STARVE_LIMIT back-to-back injects.
module spi_slave_reply_scheduler_reply_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic load_ok,
   input  logic inj_valid,
   input  logic fwd_valid,
   output logic grant_inj,
   output logic grant_fwd
);

   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

   logic [CntW-1:0] starve_q, starve_d;
   logic            force_fwd;

   // Grant decision: inject wins unless forward has been starved long enough.
   always_comb begin
      force_fwd = fwd_valid && (starve_q == CntMax);
      grant_inj = load_ok && inj_valid && !force_fwd;
      grant_fwd = load_ok && fwd_valid && !grant_inj;
   end

   // Starvation count: grows only while forward is waiting behind an inject.
   always_comb begin
      starve_d = starve_q;
      if (grant_fwd) begin
         starve_d = '0;
      end else if (grant_inj) begin
         if (!fwd_valid) begin
            starve_d = '0;
         end else if (starve_q != CntMax) begin
            starve_d = starve_q + 1'b1;
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/spi_slave_reply_scheduler.sv
// MISO-side owner for SpiSlaveDriver: loads one granted word per SS window,
// tracks the window through the driver handshake and reports the MOSI word.
module spi_slave_reply_scheduler
   import spi_slave_reply_scheduler_pkg::*;
#(
   parameter int unsigned               NUM_DATA_BITS = 8,
   parameter bit                        SS_ACTIVE_LOW = 1'b1,
   parameter int unsigned               STARVE_LIMIT  = 4,
   parameter logic [NUM_DATA_BITS-1:0]  IDLE_WORD     = '0
) (
   input  logic                     sys_clk,
   input  logic                     rst,
   input  logic                     ss_in,
   input  logic                     bus_ready,
   input  logic                     mosi_new_data,
   input  logic [NUM_DATA_BITS-1:0] mosi_data,
   output logic                     miso_send_enable,
   output logic [NUM_DATA_BITS-1:0] miso_data,
   input  logic                     inj_valid,
   output logic                     inj_ready,
   input  logic [NUM_DATA_BITS-1:0] inj_data,
   input  logic                     fwd_valid,
   output logic                     fwd_ready,
   input  logic [NUM_DATA_BITS-1:0] fwd_data,
   output logic                     rx_valid,
   output logic [NUM_DATA_BITS-1:0] rx_data,
   output logic [1:0]               rx_src,
   output logic                     abort_pulse
);

   state_e                   state_q, state_d;
   logic [NUM_DATA_BITS-1:0] miso_q, miso_d;
   logic                     en_q, en_d;
   logic [1:0]               src_q, src_d;
   logic                     rx_valid_q, rx_valid_d;
   logic [NUM_DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic [1:0]               rx_src_q, rx_src_d;
   logic                     abort_q, abort_d;
   logic                     ss_active, load_ok, grant_inj, grant_fwd;

   assign ss_active = ss_is_active(ss_in, SS_ACTIVE_LOW);
   // An SS edge in the load cycle blocks the load; rst blocks any handshake.
   assign load_ok   = (state_q == StIdle) && bus_ready && !ss_active && !rst;

   spi_slave_reply_scheduler_reply_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arbiter (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .load_ok   (load_ok),
      .inj_valid (inj_valid),
      .fwd_valid (fwd_valid),
      .grant_inj (grant_inj),
      .grant_fwd (grant_fwd)
   );

   assign inj_ready        = grant_inj;
   assign fwd_ready        = grant_fwd;
   assign miso_send_enable = en_q;
   assign miso_data        = miso_q;
   assign rx_valid         = rx_valid_q;
   assign rx_data          = rx_data_q;
   assign rx_src           = rx_src_q;
   assign abort_pulse      = abort_q;

   // Window FSM next-state and datapath updates.
   always_comb begin
      state_d    = state_q;
      miso_d     = miso_q;
      en_d       = en_q;
      src_d      = src_q;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      rx_src_d   = rx_src_q;
      abort_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ss_active) begin
               state_d = StBusy;
               en_d    = 1'b0;
               miso_d  = IDLE_WORD;
               src_d   = RxSrcNone;
            end else if (grant_inj) begin
               state_d = StArmed;
               en_d    = 1'b1;
               miso_d  = inj_data;
               src_d   = RxSrcInj;
            end else if (grant_fwd) begin
               state_d = StArmed;
               en_d    = 1'b1;
               miso_d  = fwd_data;
               src_d   = RxSrcFwd;
            end
         end
         StArmed: begin
            if (!bus_ready) state_d = StBusy;
         end
         StBusy: begin
            if (mosi_new_data) begin
               state_d    = StDone;
               rx_valid_d = 1'b1;
               rx_data_d  = mosi_data;
               rx_src_d   = src_q;
               en_d       = 1'b0;
               miso_d     = IDLE_WORD;
               src_d      = RxSrcNone;
            end else if (bus_ready && !ss_active) begin
               // SS still active means the driver's bus_ready has not caught up yet.
               abort_d = 1'b1;
               state_d = (src_q != RxSrcNone) ? StArmed : StIdle;
            end
         end
         StDone: begin
            if (bus_ready) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q    <= StIdle;
         miso_q     <= IDLE_WORD;
         en_q       <= 1'b0;
         src_q      <= RxSrcNone;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         rx_src_q   <= RxSrcNone;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         miso_q     <= miso_d;
         en_q       <= en_d;
         src_q      <= src_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         rx_src_q   <= rx_src_d;
         abort_q    <= abort_d;
      end
   end

endmodule
